tick_gen_multi: RTL and testbench

Parametrised multi-channel timebase. It produces N_CH independent enable strobes, one clk cycle wide, from the 100 MHz system clock, each with its own compile-time divisor. Each channel also produces an optional near-50% square wave, for blink and display-scan use. The block adds global run/pause and synchronous phase realignment, so all display, blink and timekeeping logic downstream shares one aligned timebase.

---
 rtl/tick_gen_multi.sv | 82 ++++++++
 tb/tb_tick_gen_multi.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// Multi-channel timebase: per-channel divide-by-D enable strobes and near-50% square waves,
// with global run/pause and synchronous phase realignment shared by all channels.
module tick_gen_multi #(
    parameter int unsigned             N_CH     = 4,
    parameter int unsigned             CNT_W    = 27,
    parameter logic [N_CH*CNT_W-1:0]   DIV_LIST = {27'd25000000, 27'd250000,
                                                   27'd100000000, 27'd50000000}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            sync_clr,
    input  logic [N_CH-1:0] ch_en,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] sq
);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $fatal(1, "tick_gen_multi: N_CH must be in 1..16");
    end

    if (CNT_W < 1) begin : g_bad_cnt_w
        $fatal(1, "tick_gen_multi: CNT_W must be at least 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam logic [CNT_W-1:0] DivVal  = DIV_LIST[i*CNT_W +: CNT_W];
        localparam bit               HasSq   = (DivVal >= CNT_W'(2));
        localparam logic [CNT_W-1:0] TermCnt = DivVal - CNT_W'(1);
        // Only meaningful when HasSq; D==1 would otherwise underflow here.
        localparam logic [CNT_W-1:0] HalfM1  = HasSq ? ((DivVal >> 1) - CNT_W'(1)) : '0;

        if (DivVal == '0) begin : g_bad_div
            $fatal(1, "tick_gen_multi: divisor of channel %0d must be non-zero", i);
        end

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             run;

        assign run = en & ch_en[i];

        always_comb begin
            cnt_d  = cnt_q;
            tick_d = 1'b0;
            sq_d   = sq_q;
            if (sync_clr) begin
                cnt_d = '0;
                sq_d  = 1'b0;
            end else if (run) begin
                if (cnt_q == TermCnt) begin
                    // sq falls on the same edge that raises tick.
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    sq_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (HasSq && (cnt_q == HalfM1)) begin
                        sq_d = 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                tick_q <= tick_d;
                sq_q   <= sq_d;
            end
        end

        assign tick[i] = tick_q;
        assign sq[i]   = sq_q;
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: directed scenarios then random traffic, compared
// against a phase-counting reference model.
module tb_tick_gen_multi;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [N_CH*CNT_W-1:0] DIVS = {8'd1, 8'd2, 8'd4, 8'd5};

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            sync_clr;
    logic [N_CH-1:0] ch_en;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] sq;

    tick_gen_multi #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .DIV_LIST(DIVS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync_clr(sync_clr),
        .ch_en   (ch_en),
        .tick    (tick),
        .sq      (sq)
    );

    always #5 clk = ~clk;

    // Reference model: enabled edges since phase 0, modulo the divisor.
    int              div_m[N_CH] = '{5, 4, 2, 1};
    int              ph[N_CH];
    logic [N_CH-1:0] exp_tick;
    logic [N_CH-1:0] exp_sq;
    int              vectors = 0;
    int              miscompares = 0;

    task automatic check_vec(input string tag, input logic [N_CH-1:0] obs,
                             input logic [N_CH-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic s,
                        input logic [N_CH-1:0] ce, input string tag);
        rst      = r;
        en       = e;
        sync_clr = s;
        ch_en    = ce;
        @(posedge clk);
        for (int i = 0; i < N_CH; i++) begin
            if (r || s) begin
                ph[i]       = 0;
                exp_tick[i] = 1'b0;
            end else if (e && ce[i]) begin
                ph[i]       = (ph[i] + 1) % div_m[i];
                exp_tick[i] = (ph[i] == 0);
            end else begin
                exp_tick[i] = 1'b0;
            end
            exp_sq[i] = (div_m[i] >= 2) && (ph[i] >= div_m[i] / 2);
        end
        #1;
        check_vec({tag, "_tick"}, tick, exp_tick);
        check_vec({tag, "_sq"}, sq, exp_sq);
    endtask

    initial begin
        int cnt;
        int edges;
        logic [N_CH-1:0] ce;
        rst = 1'b1; en = 1'b1; sync_clr = 1'b0; ch_en = 4'hF;
        for (int i = 0; i < N_CH; i++) ph[i] = 0;

        // Reset then free run
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 4'hF, "reset");
        check_vec("reset_state", tick | sq, 4'h0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b0, 4'hF, "free_run");

        // Pause/resume with 50 enabled cycles counted on ch0
        step(1'b0, 1'b1, 1'b1, 4'hF, "clr_pre_pause");
        cnt = 0;
        edges = 0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 4'hF, "pre_pause");
            edges++;
            if (tick[0]) cnt++;
        end
        check_int("pause_at_cnt3", ph[0], 3);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0, 4'hF, "paused");
        while (edges < 50) begin
            step(1'b0, 1'b1, 1'b0, 4'hF, "resumed");
            edges++;
            if (tick[0]) cnt++;
        end
        check_int("ch0_ticks_in_50", cnt, 10);

        // Terminal count on ch1 coincident with en dropping
        for (int k = 0; k < 8 && ph[1] != 3; k++) step(1'b0, 1'b1, 1'b0, 4'hF, "to_tc1");
        step(1'b0, 1'b0, 1'b0, 4'hF, "tc1_paused");
        step(1'b0, 1'b0, 1'b0, 4'hF, "tc1_paused2");
        step(1'b0, 1'b1, 1'b0, 4'hF, "tc1_resume");
        check_int("tc1_tick_after_resume", int'(tick[1]), 1);

        // sync_clr realign, then count edges to first tick[0]&tick[1] coincidence
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 4'hF, "pre_clr");
        step(1'b0, 1'b1, 1'b1, 4'hF, "sync_clr");
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b1, 1'b0, 4'hF, "realign");
            if (tick[0] && tick[1]) begin
                edges = k;
                break;
            end
        end
        check_int("coincide_edges", edges, 20);

        // sync_clr on a ch0 terminal-count edge
        for (int k = 0; k < 8 && ph[0] != 4; k++) step(1'b0, 1'b1, 1'b0, 4'hF, "to_tc0");
        step(1'b0, 1'b1, 1'b1, 4'hF, "clr_at_tc0");

        // Per-channel gate on ch0
        for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 1'b0, 4'hF, "pre_gate");
        for (int k = 0; k < 13; k++) step(1'b0, 1'b1, 1'b0, 4'b1110, "gated");
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 4'hF, "ungated");

        // Reset mid-run at cnt0==4, with sync_clr and en also asserted
        for (int k = 0; k < 8 && ph[0] != 4; k++) step(1'b0, 1'b1, 1'b0, 4'hF, "to_rst");
        step(1'b1, 1'b1, 1'b1, 4'hF, "rst_mid");
        check_vec("rst_mid_zero", tick | sq, 4'h0);
        edges = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b1, 1'b0, 4'hF, "post_rst");
            if (tick[0]) begin
                edges = k;
                break;
            end
        end
        check_int("first_tick0_after_rst", edges, 5);

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            ce = 4'($urandom);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0), ce, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
